rr_mux_arbiter: RTL and testbench

Parametrised N-to-1 data selector for the 32-bit RISC-V core. It extends the plain combinational multiplexer with per-channel valid/ready handshakes, an arbitration policy that is round-robin or fixed-priority, and a registered output stage. It sits between multiple result or request producers (ALU, load unit, CSR, multi-source bus masters) and a single downstream consumer (writeback port, memory interface), and returns the winning channel index with the data.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/rr_grant.sv | 52 +++++
 rtl/rr_mux_arbiter.sv | 74 +++++++
 tb/tb_rr_mux_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: arbitration policy encodings and the channel-index
// width helper used by the multiplexer/arbiter blocks.
package cpu_pkg;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   // A single channel still needs a 1-bit index port.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_grant.sv
// Grant generator: holds the last-granted pointer and performs the wrapped
// priority search (round-robin) or a lowest-index search (fixed priority).
module rr_grant
   import cpu_pkg::*;
#(
   parameter int N     = 8,
   parameter int SEL_W = sel_width(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             advance,
   input  arb_mode_e        mode,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] grant_idx
);

   logic [SEL_W-1:0] last;
   logic [SEL_W-1:0] pos;
   logic             found;
   int               start;
   int               idx;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = '0;
      idx       = 0;
      // The search wraps at N, not at 2**SEL_W, so unused index codes are never visited.
      if (mode == ARB_FIXED || int'(last) >= N - 1) start = 0;
      else                                          start = int'(last) + 1;
      for (int k = 0; k < N; k++) begin
         idx = start + k;
         if (idx >= N) idx = idx - N;
         pos = SEL_W'(idx);
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            grant_idx  = pos;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       last <= SEL_W'(N - 1);
      else if (advance) last <= grant_idx;
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-to-1 valid/ready multiplexer with round-robin or fixed-priority arbitration
// and a registered output stage that reports the winning channel index.
module rr_mux_arbiter
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 8,
   parameter int SEL_W = sel_width(N),
   parameter int MODE  = ARB_RR
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     in_valid,
   output logic [N-1:0]     in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [SEL_W-1:0] out_sel
);

   localparam arb_mode_e ARB_MODE = (MODE == int'(ARB_FIXED)) ? ARB_FIXED : ARB_RR;

   logic             load;
   logic             any_req;
   logic [N-1:0]     grant;
   logic [SEL_W-1:0] grant_idx;
   logic [WIDTH-1:0] sel_data;

   assign load    = !out_valid || out_ready;
   assign any_req = |in_valid;

   // Held in reset, nothing can be accepted, so no channel may see a handshake.
   assign in_ready = (rst_n && load) ? grant : '0;

   rr_grant #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_grant (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (in_valid),
      .advance   (load && any_req),
      .mode      (ARB_MODE),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // One-hot AND-OR select keeps in_data off the grant/ready path.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
      end
   end

   // NOTE: the data/index registers are reset too, so a freshly reset port reads a defined zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (load) begin
         if (any_req) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant_idx;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench: three arbiter configurations (N=8 RR, N=8 fixed, N=5 RR)
// driven from one shared stimulus set and compared against a behavioural model.
module tb_rr_mux_arbiter;
   import cpu_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [7:0]   rr_valid, rr_ready, fx_valid, fx_ready;
   logic [4:0]   n5_valid, n5_ready;
   logic         rr_ordy, fx_ordy, n5_ordy;
   logic         rr_ovalid, fx_ovalid, n5_ovalid;
   logic [W-1:0] rr_odata, fx_odata, n5_odata;
   logic [2:0]   rr_osel, fx_osel, n5_osel;
   logic [8*W-1:0] flat;

   int           active;
   logic [7:0]   st_valid;
   logic [W-1:0] st_data [8];
   logic         st_ready;

   logic         obs_valid;
   logic [W-1:0] obs_data;
   logic [31:0]  obs_sel;
   logic [7:0]   obs_ready;

   int checks = 0;
   int errors = 0;

   bit           m_valid [3];
   logic [W-1:0] m_data  [3];
   int           m_sel   [3];
   int           m_last  [3];
   int           cfg_n    [3] = '{8, 8, 5};
   int           cfg_mode [3] = '{0, 1, 0};

   always_comb begin
      for (int i = 0; i < 8; i++) flat[i*W +: W] = st_data[i];
   end

   always_comb begin
      rr_valid = '0; fx_valid = '0; n5_valid = '0;
      rr_ordy = 1'b1; fx_ordy = 1'b1; n5_ordy = 1'b1;
      obs_valid = 1'b0; obs_data = '0; obs_sel = '0; obs_ready = '0;
      case (active)
         0: begin
            rr_valid = st_valid; rr_ordy = st_ready;
            obs_valid = rr_ovalid; obs_data = rr_odata; obs_sel = 32'(rr_osel); obs_ready = rr_ready;
         end
         1: begin
            fx_valid = st_valid; fx_ordy = st_ready;
            obs_valid = fx_ovalid; obs_data = fx_odata; obs_sel = 32'(fx_osel); obs_ready = fx_ready;
         end
         default: begin
            n5_valid = st_valid[4:0]; n5_ordy = st_ready;
            obs_valid = n5_ovalid; obs_data = n5_odata; obs_sel = 32'(n5_osel); obs_ready = {3'b000, n5_ready};
         end
      endcase
   end

   rr_mux_arbiter #(.WIDTH(W), .N(8), .MODE(ARB_RR)) dut_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(rr_valid), .in_ready(rr_ready), .in_data(flat),
      .out_valid(rr_ovalid), .out_ready(rr_ordy), .out_data(rr_odata), .out_sel(rr_osel));

   rr_mux_arbiter #(.WIDTH(W), .N(8), .MODE(ARB_FIXED)) dut_fx (
      .clk(clk), .rst_n(rst_n), .in_valid(fx_valid), .in_ready(fx_ready), .in_data(flat),
      .out_valid(fx_ovalid), .out_ready(fx_ordy), .out_data(fx_odata), .out_sel(fx_osel));

   rr_mux_arbiter #(.WIDTH(W), .N(5), .MODE(ARB_RR)) dut_n5 (
      .clk(clk), .rst_n(rst_n), .in_valid(n5_valid), .in_ready(n5_ready), .in_data(flat[5*W-1:0]),
      .out_valid(n5_ovalid), .out_ready(n5_ordy), .out_data(n5_odata), .out_sel(n5_osel));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Winner under the policy rules: fixed scans 0..n-1, round-robin scans from last+1 modulo n.
   function automatic int pick(input int d);
      int c;
      for (int k = 0; k < cfg_n[d]; k++) begin
         c = (cfg_mode[d] == 1) ? k : (m_last[d] + 1 + k) % cfg_n[d];
         if (st_valid[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_valid[d] = 1'b0;
         m_data[d]  = '0;
         m_sel[d]   = 0;
         m_last[d]  = cfg_n[d] - 1;
      end
   endtask

   // One clock of the active configuration; inputs are already applied by the caller.
   task automatic cycle(input string tag);
      bit         load;
      int         w;
      logic [7:0] exp_rdy;
      #1;
      load    = !m_valid[active] || st_ready;
      w       = load ? pick(active) : -1;
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      check({tag, ".in_ready"}, 32'(obs_ready), 32'(exp_rdy));
      @(posedge clk);
      for (int d = 0; d < 3; d++) if (d != active) m_valid[d] = 1'b0;
      if (load) begin
         if (w >= 0) begin
            m_valid[active] = 1'b1;
            m_data[active]  = st_data[w];
            m_sel[active]   = w;
            m_last[active]  = w;
         end else begin
            m_valid[active] = 1'b0;
         end
      end
      #1;
      check({tag, ".out_valid"}, 32'(obs_valid), 32'(m_valid[active]));
      check({tag, ".out_data"},  obs_data, m_data[active]);
      check({tag, ".out_sel"},   obs_sel, 32'(m_sel[active]));
   endtask

   task automatic do_reset(input string tag);
      st_valid = '1;
      st_ready = 1'b1;
      rst_n    = 1'b0;
      #2;
      check({tag, ".valid"}, {29'b0, rr_ovalid, fx_ovalid, n5_ovalid}, 32'd0);
      check({tag, ".data"},  rr_odata | fx_odata | n5_odata, 32'd0);
      check({tag, ".sel"},   32'(rr_osel | fx_osel | n5_osel), 32'd0);
      check({tag, ".ready"}, {11'b0, rr_ready, fx_ready, n5_ready}, 32'd0);
      @(posedge clk);
      #1;
      check({tag, ".ready_hold"}, {11'b0, rr_ready, fx_ready, n5_ready}, 32'd0);
      check({tag, ".valid_hold"}, {29'b0, rr_ovalid, fx_ovalid, n5_ovalid}, 32'd0);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_n    = 1'b0;
      active   = 0;
      st_valid = '0;
      st_ready = 1'b1;
      for (int i = 0; i < 8; i++) st_data[i] = '0;
      model_reset();
      #7;
      do_reset("reset");

      // Round-robin fairness, first grant after reset goes to channel 0.
      active   = 0;
      st_valid = 8'hFF;
      for (int i = 0; i < 8; i++) st_data[i] = 32'h100 + 32'(i);
      for (int i = 0; i < 9; i++) begin
         cycle("rr_fair");
         check("rr_fair.seq_sel",  obs_sel, 32'(i % 8));
         check("rr_fair.seq_data", obs_data, 32'h100 + 32'(i % 8));
      end

      // Backpressure: beat from channel 1 held for three stalled cycles.
      st_data[1] = 32'hDEADBEEF;
      cycle("bp_load");
      check("bp_load.data", obs_data, 32'hDEADBEEF);
      st_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle("bp_stall");
         check("bp_stall.data",  obs_data, 32'hDEADBEEF);
         check("bp_stall.ready", 32'(obs_ready), 32'd0);
      end
      st_ready = 1'b1;
      cycle("bp_release");
      check("bp_release.sel", obs_sel, 32'd2);

      // Sparse request then bubble; the following search starts after channel 6.
      st_valid = 8'h40;
      cycle("sparse6");
      check("sparse6.sel", obs_sel, 32'd6);
      st_valid = 8'h00;
      cycle("bubble");
      check("bubble.valid", 32'(obs_valid), 32'd0);
      st_valid = 8'h88;
      cycle("sparse37a");
      check("sparse37a.sel", obs_sel, 32'd7);
      cycle("sparse37b");
      check("sparse37b.sel", obs_sel, 32'd3);

      // Fixed priority: channel 2 beats channel 5 until it drops.
      active   = 1;
      st_valid = 8'h24;
      for (int i = 0; i < 4; i++) begin
         cycle("fixed25");
         check("fixed25.sel", obs_sel, 32'd2);
      end
      st_valid = 8'h20;
      cycle("fixed5");
      check("fixed5.sel", obs_sel, 32'd5);

      // Non-power-of-two wrap.
      active   = 2;
      st_valid = 8'h1F;
      for (int i = 0; i < 5; i++) st_data[i] = 32'h200 + 32'(i);
      for (int i = 0; i < 6; i++) begin
         cycle("n5_wrap");
         check("n5_wrap.seq_sel", obs_sel, 32'(i % 5));
      end

      // Reset asserted while a beat is stalled in the output register.
      active   = 0;
      st_valid = 8'hFF;
      cycle("mid_load");
      st_ready = 1'b0;
      cycle("mid_stall");
      check("mid_stall.valid", 32'(obs_valid), 32'd1);
      do_reset("mid_reset");

      // Randomised traffic on every configuration.
      for (int d = 0; d < 3; d++) begin
         active = d;
         for (int c = 0; c < 400; c++) begin
            st_valid = 8'($urandom);
            for (int i = 0; i < 8; i++) st_data[i] = $urandom;
            st_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
